// File: rtl/rx_sequencer.sv
// Receive sequencer: takes demodulated words, runs them through the decoder, and
// stores decoded bytes in a register-field ring buffer with a status byte.
module rx_sequencer #(
  parameter int unsigned DEC_TIMEOUT = 255,
  parameter logic [7:0]  RX_BASE     = 8'h10,
  parameter int unsigned RX_DEPTH    = 8,
  parameter logic [7:0]  RX_STAT     = 8'h0F
) (
  input  logic        G_CLK_RX,
  input  logic        reset,
  input  logic        rx_enable_cfg,
  input  logic        dm_status,
  input  logic [15:0] dm_data,
  output logic        rx_enable,
  output logic        dc_start,
  output logic [15:0] dc_data,
  input  logic        dc_done,
  input  logic        dc_error,
  input  logic [7:0]  dc_byte,
  output logic        rf_we,
  output logic [7:0]  rf_addr,
  output logic [7:0]  rf_wdata,
  input  logic        host_ack,
  output logic [3:0]  rd_ptr,
  output logic        int_rx_host
);

  localparam logic [3:0] PtrLast    = 4'(RX_DEPTH - 1);
  localparam logic [4:0] CntFull    = 5'(RX_DEPTH);
  localparam logic [7:0] TimeoutVal = 8'(DEC_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StArmed, StDecode, StStore, StStat} state_e;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d, to_q, to_d, err_q, err_d;
  logic        store_inc, ack_ok;

  logic        rx_enable_q, rx_enable_d;
  logic        dc_start_q, dc_start_d;
  logic [15:0] dc_data_q, dc_data_d;
  logic        rf_we_q, rf_we_d;
  logic [7:0]  rf_addr_q, rf_addr_d;
  logic [7:0]  rf_wdata_q, rf_wdata_d;
  logic        int_rx_q, int_rx_d;

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == PtrLast) ? 4'd0 : p + 4'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dc_data_d = dc_data_q;
    ovf_d     = ovf_q;
    to_d      = to_q;
    err_d     = err_q;
    store_inc = 1'b0;
    ack_ok    = host_ack && (count_q != 5'd0);

    case (state_q)
      StIdle: begin
        ovf_d = 1'b0;
        to_d  = 1'b0;
        err_d = 1'b0;
        if (rx_enable_cfg) state_d = StArmed;
      end
      StArmed: begin
        if (dm_status) begin
          dc_data_d = dm_data;
          timer_d   = 8'd0;
          state_d   = StDecode;
        end else if (!rx_enable_cfg) begin
          state_d = StIdle;
        end
      end
      StDecode: begin
        timer_d = timer_q + 8'd1;
        if (dc_done) begin
          if (dc_error) begin
            err_d   = 1'b1;
            state_d = StArmed;
          end else begin
            state_d = StStore;
          end
        end else if (timer_q == TimeoutVal) begin
          to_d    = 1'b1;
          state_d = StArmed;
        end
      end
      StStore: begin
        // rf_we_q holds the room-available decision taken on entry to this state
        if (rf_we_q) begin
          wr_ptr_d  = ptr_inc(wr_ptr_q);
          store_inc = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = StStat;
      end
      StStat: begin
        state_d = rx_enable_cfg ? StArmed : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (ack_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (store_inc && !ack_ok) begin
      count_d = count_q + 5'd1;
    end else if (!store_inc && ack_ok) begin
      count_d = count_q - 5'd1;
    end

    // Outputs are registered, so they are decoded from the state being entered.
    rx_enable_d = (state_d == StArmed);
    dc_start_d  = (state_q == StArmed) && (state_d == StDecode);
    rf_we_d     = 1'b0;
    rf_addr_d   = 8'd0;
    rf_wdata_d  = 8'd0;
    if (state_d == StStore) begin
      if (count_d < CntFull) begin
        rf_we_d    = 1'b1;
        rf_addr_d  = RX_BASE + {4'd0, wr_ptr_q};
        rf_wdata_d = dc_byte;
      end
    end else if (state_d == StStat) begin
      rf_we_d    = 1'b1;
      rf_addr_d  = RX_STAT;
      rf_wdata_d = {ovf_d, to_d, err_d, count_d};
    end
    int_rx_d = (count_q != 5'd0);
  end

  always_ff @(posedge G_CLK_RX or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      timer_q     <= 8'd0;
      count_q     <= 5'd0;
      wr_ptr_q    <= 4'd0;
      rd_ptr_q    <= 4'd0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      err_q       <= 1'b0;
      rx_enable_q <= 1'b0;
      dc_start_q  <= 1'b0;
      dc_data_q   <= 16'd0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= 8'd0;
      rf_wdata_q  <= 8'd0;
      int_rx_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      err_q       <= err_d;
      rx_enable_q <= rx_enable_d;
      dc_start_q  <= dc_start_d;
      dc_data_q   <= dc_data_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      int_rx_q    <= int_rx_d;
    end
  end

  assign rx_enable   = rx_enable_q;
  assign dc_start    = dc_start_q;
  assign dc_data     = dc_data_q;
  assign rf_we       = rf_we_q;
  assign rf_addr     = rf_addr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rd_ptr      = rd_ptr_q;
  assign int_rx_host = int_rx_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// Bench for rx_sequencer: directed scenarios plus random traffic, all checked each
// cycle against a behavioural model of the receive flow and ring buffer.
module tb_rx_sequencer;

  localparam int MIdle = 0, MArmed = 1, MDecode = 2, MStore = 3, MStat = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg = 1'b0, dms = 1'b0, done = 1'b0, derr = 1'b0, ack = 1'b0;
  logic [15:0] dmd = 16'd0;
  logic [7:0]  dbyte = 8'd0;
  logic        rx_enable, dc_start, rf_we, int_rx_host;
  logic [15:0] dc_data;
  logic [7:0]  rf_addr, rf_wdata;
  logic [3:0]  rd_ptr;

  always #5 clk = ~clk;

  rx_sequencer dut (
    .G_CLK_RX     (clk),
    .reset        (rst_n),
    .rx_enable_cfg(cfg),
    .dm_status    (dms),
    .dm_data      (dmd),
    .rx_enable    (rx_enable),
    .dc_start     (dc_start),
    .dc_data      (dc_data),
    .dc_done      (done),
    .dc_error     (derr),
    .dc_byte      (dbyte),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_wdata     (rf_wdata),
    .host_ack     (ack),
    .rd_ptr       (rd_ptr),
    .int_rx_host  (int_rx_host)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model: phase of the receive flow, bytes held, ring indices.
  int          m_mode, m_count, m_wr, m_rd, m_dcyc;
  bit          m_ovf, m_to, m_err, m_pend;
  logic [7:0]  m_byte;
  logic        e_rx_en, e_start, e_we, e_int;
  logic [15:0] e_dcdata;
  logic [7:0]  e_addr, e_wdata;
  logic [3:0]  e_rd;
  logic [15:0] wlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_count = 0; m_wr = 0; m_rd = 0; m_dcyc = 0;
    m_ovf = 0; m_to = 0; m_err = 0; m_pend = 0; m_byte = 8'd0;
    e_rx_en = 0; e_start = 0; e_we = 0; e_int = 0;
    e_dcdata = 16'd0; e_addr = 8'd0; e_wdata = 8'd0; e_rd = 4'd0;
  endtask

  // Advance the model by one clock given the inputs currently driven.
  task automatic model_step();
    int  held_before = m_count;
    int  nmode = m_mode;
    int  added = 0;
    int  taken = 0;
    case (m_mode)
      MIdle: begin
        m_ovf = 0; m_to = 0; m_err = 0;
        if (cfg) nmode = MArmed;
      end
      MArmed: begin
        if (dms) begin
          e_dcdata = dmd; m_dcyc = 0; nmode = MDecode;
        end else if (!cfg) nmode = MIdle;
      end
      MDecode: begin
        if (done) begin
          if (derr) begin m_err = 1; nmode = MArmed; end
          else begin m_byte = dbyte; nmode = MStore; end
        end else if (m_dcyc == 255) begin
          m_to = 1; nmode = MArmed;
        end
        m_dcyc++;
      end
      MStore: begin
        if (m_pend) begin added = 1; m_wr = (m_wr + 1) % 8; end
        else m_ovf = 1;
        nmode = MStat;
      end
      default: nmode = cfg ? MArmed : MIdle;
    endcase
    if (ack && held_before > 0) begin taken = 1; m_rd = (m_rd + 1) % 8; end
    m_count = held_before + added - taken;
    e_rx_en = (nmode == MArmed);
    e_start = (m_mode == MArmed) && (nmode == MDecode);
    e_we = 0;
    m_pend = 0;
    if (nmode == MStore) begin
      m_pend = (m_count < 8);
      e_we = m_pend; e_addr = 8'h10 + 8'(m_wr); e_wdata = m_byte;
    end else if (nmode == MStat) begin
      e_we = 1; e_addr = 8'h0F; e_wdata = {m_ovf, m_to, m_err, 5'(m_count)};
    end
    e_rd = 4'(m_rd);
    e_int = (held_before != 0);
    m_mode = nmode;
  endtask

  // Called just after a falling edge with inputs set; compares after the next rise.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("rx_enable", rx_enable, e_rx_en);
    check("dc_start", dc_start, e_start);
    check("dc_data", dc_data, e_dcdata);
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_addr", rf_addr, e_addr);
      check("rf_wdata", rf_wdata, e_wdata);
    end
    check("rd_ptr", rd_ptr, e_rd);
    check("int_rx_host", int_rx_host, e_int);
    if (rf_we) wlog.push_back({rf_addr, rf_wdata});
    @(negedge clk);
  endtask

  task automatic reset_dut();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst rx_enable", rx_enable, 0);
    check("rst dc_start", dc_start, 0);
    check("rst dc_data", dc_data, 0);
    check("rst rf_we", rf_we, 0);
    check("rst rf_addr", rf_addr, 0);
    check("rst rf_wdata", rf_wdata, 0);
    check("rst rd_ptr", rd_ptr, 0);
    check("rst int", int_rx_host, 0);
    model_reset();
    dms = 0; done = 0; derr = 0; ack = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed_byte(input logic [7:0] b, input int lat, input bit err,
                           input bit ack_store, input bit ack_after);
    cfg = 1; dms = 0; done = 0; ack = 0;
    for (int k = 0; k < 8 && m_mode != MArmed; k++) step();
    dms = 1; dmd = 16'($urandom); step(); dms = 0;
    for (int k = 0; k < lat; k++) step();
    done = 1; derr = err; dbyte = b; step(); done = 0; derr = 0;
    if (!err) begin
      ack = ack_store; step(); ack = 0;
      step();
    end
    if (ack_after) begin ack = 1; step(); ack = 0; end
  endtask

  int nstore;
  int dlat;
  int ack_p;

  initial begin
    model_reset();
    reset_dut();

    // Nominal word
    wlog.delete();
    cfg = 1; step();
    dms = 1; dmd = 16'hA55A; step(); dms = 0;
    check("lit dc_data", dc_data, 16'hA55A);
    check("lit dc_start first", dc_start, 1);
    step();
    check("lit dc_start second", dc_start, 0);
    step(); step();
    done = 1; dbyte = 8'h3C; step(); done = 0;
    step(); step(); step();
    check("lit nominal writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("lit store", wlog[0], 16'h103C);
      check("lit status", wlog[1], 16'h0F01);
    end
    check("lit int", int_rx_host, 1);

    // Overflow: nine bytes, no reads
    reset_dut(); wlog.delete();
    for (int i = 0; i < 9; i++) feed_byte(8'(i + 1), int'($urandom_range(0, 3)), 0, 0, 0);
    nstore = 0;
    foreach (wlog[i]) if (wlog[i][15:8] != 8'h0F) begin
      check("lit ovf addr", wlog[i][15:8], 8'h10 + 8'(nstore));
      nstore++;
    end
    check("lit ovf nstore", nstore, 8);
    check("lit ovf status", wlog[wlog.size() - 1], 16'h0F88);

    // Timeout after 256 decode cycles
    reset_dut(); wlog.delete();
    cfg = 1; step();
    dms = 1; step(); dms = 0;
    repeat (255) step();
    check("lit to still decoding", rx_enable, 0);
    step();
    check("lit to rearmed", rx_enable, 1);
    check("lit to no writes", wlog.size(), 0);
    feed_byte(8'h5A, 1, 0, 0, 0);
    check("lit to store", wlog[0], 16'h105A);
    check("lit to status", wlog[1], 16'h0F41);

    // host_ack coincident with a store
    reset_dut(); wlog.delete();
    for (int i = 0; i < 3; i++) feed_byte(8'hA0 + 8'(i), 0, 0, 0, 0);
    feed_byte(8'hB3, 2, 0, 1, 0);
    check("lit simul status", wlog[wlog.size() - 1], 16'h0F03);
    check("lit simul rd_ptr", rd_ptr, 1);
    feed_byte(8'hB4, 0, 0, 0, 0);
    check("lit simul next", wlog[wlog.size() - 2], 16'h14B4);

    // Wrap with a read after every byte
    reset_dut(); wlog.delete();
    for (int i = 0; i < 10; i++) feed_byte(8'(8'h40 + i), 1, 0, 0, 1);
    nstore = 0;
    foreach (wlog[i]) if (wlog[i][15:8] != 8'h0F) begin
      check("lit wrap addr", wlog[i][15:8], 8'h10 + 8'(nstore % 8));
      nstore++;
    end
    check("lit wrap nstore", nstore, 10);
    check("lit wrap rd_ptr", rd_ptr, 2);

    // Reset while decoding
    wlog.delete();
    cfg = 1; dms = 1; step(); dms = 0;
    step(); step();
    reset_dut();
    cfg = 1; step();
    check("lit rearm", rx_enable, 1);
    done = 1; dbyte = 8'hEE; step(); done = 0;
    step(); step();
    check("lit no write after reset", wlog.size(), 0);

    // Random traffic
    dlat = 0;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) ack_p = int'($urandom_range(0, 2));
      cfg = ($urandom % 16) != 0;
      dms = ($urandom % 4) == 0;
      dmd = 16'($urandom);
      dbyte = 8'($urandom);
      derr = ($urandom % 5) == 0;
      case (ack_p)
        0: ack = 1'b0;
        1: ack = ($urandom % 8) == 0;
        default: ack = ($urandom % 2) == 0;
      endcase
      if (m_mode == MDecode) begin
        if (m_dcyc == 0) dlat = (($urandom % 40) == 0) ? 300 : int'($urandom_range(0, 5));
        done = (m_dcyc == dlat);
      end else begin
        done = ($urandom % 20) == 0;
      end
      if (($urandom % 1500) == 0) reset_dut();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_sequencer.md
RX_SEQUENCER -- requirements
Module: rx_sequencer

Interface
REQ-001 SHALL have parameters: DEC_TIMEOUT, default 255, max cycles in DECODE awaiting dc_done; RX_BASE, default 8'h10, first register-field address of receive buffer; RX_DEPTH, default 8 (power of 2, max 16), buffer entries; RX_STAT, default 8'h0F, register-field address of status byte.
REQ-002 SHALL have ports, in order:
- G_CLK_RX  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- rx_enable_cfg  in  1  host control bit, receive enabled
- dm_status  in  1  demodulator word-valid pulse
- dm_data  in  16  demodulator word
- rx_enable  out  1  demodulator enable
- dc_start  out  1  decoder start pulse
- dc_data  out  16  word to decoder
- dc_done  in  1  decoder finished
- dc_error  in  1  decode failed, valid with dc_done
- dc_byte  in  8  decoded byte, valid with dc_done
- rf_we  out  1  register-field write strobe
- rf_addr  out  8  register-field address
- rf_wdata  out  8  register-field write data
- host_ack  in  1  host consumed one byte, one-cycle pulse
- rd_ptr  out  4  buffer index of oldest unread byte
- int_rx_host  out  1  receive interrupt to host

Function
REQ-003 SHALL register all outputs; reset is asynchronous, active-low.
REQ-004 SHALL implement FSM states IDLE, ARMED, DECODE, STORE, STAT.
REQ-005 IDLE: rx_enable=0; SHALL go to ARMED next cycle when rx_enable_cfg=1.
REQ-006 ARMED: rx_enable=1; dm_status=1 SHALL latch dm_data into dc_data and go to DECODE; else rx_enable_cfg=0 SHALL go to IDLE; dm_status takes priority.
REQ-007 DECODE: dc_start SHALL be 1 only in first DECODE cycle; 8-bit timer SHALL clear on entry and increment each DECODE cycle.
REQ-008 DECODE, dc_done=1, dc_error=1: err_flag SHALL set; next state ARMED.
REQ-009 DECODE, dc_done=1, dc_error=0: dc_byte SHALL be latched; next state STORE.
REQ-010 DECODE, timer==DEC_TIMEOUT without dc_done: to_flag SHALL set; next state ARMED; dc_done in that same cycle wins over timeout.
REQ-011 STORE with count<RX_DEPTH: rf_we=1, rf_addr=RX_BASE+wr_ptr, rf_wdata=latched byte; wr_ptr increments mod RX_DEPTH; count increments.
REQ-012 STORE with count==RX_DEPTH: no write; ovf_flag SHALL set; byte dropped.
REQ-013 STORE SHALL always go to STAT.
REQ-014 STAT: rf_we=1, rf_addr=RX_STAT, rf_wdata={ovf_flag, to_flag, err_flag, count[4:0]}; next state ARMED if rx_enable_cfg=1, else IDLE.
REQ-015 rx_enable_cfg=0 SHALL NOT abort DECODE, STORE or STAT; it takes effect in ARMED or at STAT exit.
REQ-016 host_ack with count>0 SHALL decrement count and increment rd_ptr mod RX_DEPTH; host_ack with count==0 SHALL be ignored.
REQ-017 host_ack in same cycle as a STORE increment SHALL leave count unchanged; rd_ptr still advances.
REQ-018 int_rx_host SHALL be 1 exactly when count!=0 (registered, one cycle after count change).
REQ-019 ovf_flag, to_flag, err_flag SHALL be sticky; all three SHALL clear in any cycle in IDLE.
REQ-020 rf_we SHALL be 0 in all states except STORE (non-full) and STAT.

Reset
REQ-021 reset=0 SHALL immediately force state IDLE and all outputs, pointers, count, timer and flags to 0.
REQ-022 reset asserted mid-DECODE or mid-STORE SHALL abandon the word with no register-field write after release.

Verification
REQ-023 Nominal: cfg=1, dm_status pulse with dm_data=16'hA55A, dc_done with dc_byte=8'h3C after 4 cycles -> dc_data=16'hA55A, one-cycle dc_start, write 8'h3C @8'h10, then 8'h01 @8'h0F, int_rx_host=1.
REQ-024 Overflow: 9 good bytes, no host_ack, RX_DEPTH=8 -> 8 buffer writes @8'h10..8'h17; 9th gives status write only, rf_wdata=8'h88.
REQ-025 Timeout: dc_done never arrives -> return to ARMED after 256 DECODE cycles; status unchanged until next STAT; to_flag=1 visible at bit 6.
REQ-026 Simultaneous: host_ack in same cycle as STORE with count=3 -> count stays 3, rd_ptr+1, next write @RX_BASE+wr_ptr.
REQ-027 Reset mid-DECODE: reset=0 for 1 cycle -> all outputs 0 immediately, no rf_we after release; cfg=1 re-arms ARMED after 1 cycle.
REQ-028 Wrap: 10 bytes with host_ack after each -> wr_ptr/rd_ptr wrap 7->0; writes at 8'h10..8'h17, 8'h10, 8'h11.
